// File: rtl/gpio_cfg_loader.sv
// Sequencer that fetches one config word per pad and shifts the words MSB-first down the GPIO pad chain.
// state | meaning: IDLE wait start | SRST clear chain | FETCH get word | SHIFT clock bits out | LOAD latch strobe | DONE done pulse
module gpio_cfg_loader #(
    parameter int NUM_PADS      = 6,
    parameter int PAD_CTRL_BITS = 16,
    parameter int CLK_DIV       = 2,
    parameter int IDX_W         = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                     mclk,
    input  logic                     reset_n,
    input  logic                     cfg_start,
    output logic                     cfg_busy,
    output logic                     cfg_done,
    output logic                     cfg_rd_req,
    output logic [IDX_W-1:0]         cfg_rd_idx,
    input  logic [PAD_CTRL_BITS-1:0] cfg_rd_data,
    input  logic                     cfg_rd_ack,
    output logic                     serial_shift_rstn,
    output logic                     serial_clock,
    output logic                     serial_data,
    output logic                     serial_load
);

    localparam int BIT_W = $clog2(PAD_CTRL_BITS) + 1;
    localparam int PH_W  = $clog2(CLK_DIV) + 1;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAD_CTRL_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PADS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SRST,
        S_FETCH,
        S_SHIFT,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [PH_W-1:0]          ph_q, ph_d;
    logic                     hi_q, hi_d;
    logic [PAD_CTRL_BITS-1:0] sr_q, sr_d;
    logic                     data_q, data_d;
    logic [PAD_CTRL_BITS-1:0] sr_shl;
    logic                     ph_end;

    // A timed window is a low half then a high half of CLK_DIV cycles each.
    assign ph_end = hi_q && (ph_q == '0);
    assign sr_shl = sr_q << 1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        ph_d    = ph_q;
        hi_d    = hi_q;
        sr_d    = sr_q;
        data_d  = data_q;

        if (state_q == S_SRST || state_q == S_SHIFT || state_q == S_LOAD) begin
            if (ph_q != '0) begin
                ph_d = ph_q - PH_W'(1);
            end else if (!hi_q) begin
                hi_d = 1'b1;
                ph_d = PH_LAST;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    state_d = S_SRST;
                    idx_d   = IDX_LAST;
                    ph_d    = PH_LAST;
                    hi_d    = 1'b0;
                end
            end
            S_SRST: begin
                if (ph_end) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (cfg_rd_ack) begin
                    state_d = S_SHIFT;
                    sr_d    = cfg_rd_data;
                    data_d  = cfg_rd_data[PAD_CTRL_BITS-1];
                    bit_d   = BIT_LAST;
                    ph_d    = PH_LAST;
                    hi_d    = 1'b0;
                end
            end
            S_SHIFT: begin
                if (ph_end) begin
                    ph_d = PH_LAST;
                    hi_d = 1'b0;
                    if (bit_q != '0) begin
                        bit_d  = bit_q - BIT_W'(1);
                        sr_d   = sr_shl;
                        data_d = sr_shl[PAD_CTRL_BITS-1];
                    end else if (idx_q != '0) begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (ph_end) begin
                    state_d = S_DONE;
                    data_d  = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            bit_q   <= '0;
            ph_q    <= '0;
            hi_q    <= 1'b0;
            sr_q    <= '0;
            data_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            ph_q    <= ph_d;
            hi_q    <= hi_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
        end
    end

    assign cfg_busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign cfg_done          = (state_q == S_DONE);
    assign cfg_rd_req        = (state_q == S_FETCH);
    assign cfg_rd_idx        = idx_q;
    assign serial_shift_rstn = (state_q != S_SRST);
    assign serial_clock      = (state_q == S_SHIFT) && hi_q;
    assign serial_data       = data_q;
    assign serial_load       = (state_q == S_LOAD);

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// Bench for gpio_cfg_loader: two instances (2 pads/CLK_DIV=1 and 6 pads/CLK_DIV=3) against a pad-chain model.
module tb_gpio_cfg_loader;

    logic mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic        reset_n;
    logic [1:0]  start = '0;
    logic [1:0]  spur = '0;
    logic [1:0]  ackm = '0;
    logic [1:0]  busy, done, req, ack, rstn, sclk, sdata, load;
    logic        idx_a;
    logic [2:0]  idx_b;
    logic [15:0] rd_a, rd_b;
    logic [15:0] junk = '0;
    logic [15:0] words_a [2];
    logic [15:0] words_b [6];
    int          dly_a [2];
    int          dly_b [6];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    always @(posedge mclk) cyc <= cyc + 1;

    assign ack  = ackm | spur;
    assign rd_a = req[0] ? words_a[idx_a] : junk;
    assign rd_b = req[1] ? words_b[idx_b] : junk;

    gpio_cfg_loader #(.NUM_PADS(2), .PAD_CTRL_BITS(16), .CLK_DIV(1)) dut_a (
        .mclk(mclk), .reset_n(reset_n), .cfg_start(start[0]), .cfg_busy(busy[0]),
        .cfg_done(done[0]), .cfg_rd_req(req[0]), .cfg_rd_idx(idx_a), .cfg_rd_data(rd_a),
        .cfg_rd_ack(ack[0]), .serial_shift_rstn(rstn[0]), .serial_clock(sclk[0]),
        .serial_data(sdata[0]), .serial_load(load[0]));

    gpio_cfg_loader #(.NUM_PADS(6), .PAD_CTRL_BITS(16), .CLK_DIV(3)) dut_b (
        .mclk(mclk), .reset_n(reset_n), .cfg_start(start[1]), .cfg_busy(busy[1]),
        .cfg_done(done[1]), .cfg_rd_req(req[1]), .cfg_rd_idx(idx_b), .cfg_rd_data(rd_b),
        .cfg_rd_ack(ack[1]), .serial_shift_rstn(rstn[1]), .serial_clock(sclk[1]),
        .serial_data(sdata[1]), .serial_load(load[1]));

    function automatic int cd(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int np(int d);
        return (d == 0) ? 2 : 6;
    endfunction

    function automatic logic [15:0] word(int d, int p);
        if (d == 0) return words_a[p];
        return words_b[p];
    endfunction

    function automatic int exp_lat(int d, int extra);
        return 1 + 2*cd(d) + np(d)*(1 + 2*cd(d)*16) + 2*cd(d) + extra;
    endfunction

    // Config source: ack after the configured number of wait cycles.
    int wcnt [2];
    always @(negedge mclk) begin
        for (int d = 0; d < 2; d++) begin
            if (req[d]) begin
                ackm[d] <= (wcnt[d] == ((d == 0) ? dly_a[idx_a] : dly_b[idx_b]));
                wcnt[d] <= wcnt[d] + 1;
            end else begin
                ackm[d] <= 1'b0;
                wcnt[d] <= 0;
            end
        end
    end

    // Pad-chain model plus serial timing monitor.
    int          ncap [2];
    bit          cap [2][128];
    int          load_cyc [2], rstn_low [2], done_cnt [2], clk_err [2], stab_err [2], phase_err [2];
    int          hi_run [2], lo_run [2], nfetch [2];
    int          fidx [2][8];
    bit          lo_req [2] = '{1'b1, 1'b1};
    bit          sclk_prev [2], sdata_prev [2], load_prev [2], req_prev [2];
    logic [95:0] chain [2];
    logic [15:0] pads [2][6];

    always @(negedge mclk) begin
        for (int d = 0; d < 2; d++) begin
            if (sclk[d]) begin
                if (!sclk_prev[d]) begin
                    if (!lo_req[d] && lo_run[d] != cd(d)) phase_err[d]++;
                    if (ncap[d] < 128) cap[d][ncap[d]] = sdata[d];
                    ncap[d]++;
                    chain[d] = {chain[d][94:0], sdata[d]};
                    hi_run[d] = 0;
                end
                hi_run[d]++;
                if (sdata[d] !== sdata_prev[d]) stab_err[d]++;
            end else begin
                if (sclk_prev[d]) begin
                    if (hi_run[d] != cd(d)) phase_err[d]++;
                    lo_run[d] = 0;
                    lo_req[d] = 1'b0;
                end
                lo_run[d]++;
                if (req[d]) lo_req[d] = 1'b1;
            end
            if ((req[d] || load[d] || !rstn[d]) && sclk[d]) clk_err[d]++;
            if (req[d] && !req_prev[d]) begin
                fidx[d][nfetch[d] % 8] = (d == 0) ? int'(idx_a) : int'(idx_b);
                nfetch[d]++;
            end
            if (load[d]) load_cyc[d]++;
            if (load[d] && !load_prev[d])
                for (int p = 0; p < np(d); p++) pads[d][p] = chain[d][p*16 +: 16];
            if (!rstn[d]) rstn_low[d]++;
            if (done[d]) done_cnt[d]++;
            sclk_prev[d]  = sclk[d];
            sdata_prev[d] = sdata[d];
            load_prev[d]  = load[d];
            req_prev[d]   = req[d];
        end
    end

    task automatic clear_mon(int d);
        ncap[d] = 0; load_cyc[d] = 0; rstn_low[d] = 0; done_cnt[d] = 0; nfetch[d] = 0;
        clk_err[d] = 0; stab_err[d] = 0; phase_err[d] = 0; lo_req[d] = 1'b1;
    endtask

    task automatic run_seq(int d, int budget, output int lat, output bit ok);
        int n;
        int st;
        clear_mon(d);
        @(negedge mclk);
        start[d] = 1'b1;
        st = cyc;
        @(negedge mclk);
        start[d] = 1'b0;
        n = 0;
        while (!done[d] && n < budget) begin
            @(negedge mclk);
            n++;
        end
        ok  = done[d];
        lat = cyc - st;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge mclk);
        checks++; if (busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b exp 00", busy); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b exp 00", done); end
        checks++; if (req !== 2'b00) begin errors++; $display("FAIL reset_req: got %b exp 00", req); end
        checks++; if ({idx_b, idx_a} !== 4'd0) begin errors++; $display("FAIL reset_idx: got %h exp 0", {idx_b, idx_a}); end
        checks++; if (rstn !== 2'b11) begin errors++; $display("FAIL reset_rstn: got %b exp 11", rstn); end
        checks++; if ({sclk, sdata, load} !== 6'd0) begin errors++; $display("FAIL reset_serial: got %b exp 0", {sclk, sdata, load}); end
        reset_n = 1'b1;
        repeat (4) @(negedge mclk);
        checks++; if (busy !== 2'b00) begin errors++; $display("FAIL idle_busy: got %b exp 00", busy); end
    endtask

    task automatic test_basic();
        int lat;
        bit ok;
        logic [31:0] got;
        words_a[1] = 16'hA5C3;
        words_a[0] = 16'h3000;
        for (int m = 0; m < 2; m++) begin
            dly_a[0] = 3*m;
            dly_a[1] = 3*m;
            run_seq(0, 500, lat, ok);
            repeat (5) @(negedge mclk);
            got = '0;
            for (int k = 0; k < 32; k++) got = {got[30:0], cap[0][k]};
            checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no done exp done (mode %0d)", m); end
            checks++; if (lat != 71 + 6*m) begin errors++; $display("FAIL basic_latency: got %0d exp %0d", lat, 71 + 6*m); end
            checks++; if (ncap[0] != 32) begin errors++; $display("FAIL basic_rises: got %0d exp 32", ncap[0]); end
            checks++; if (got !== 32'hA5C33000) begin errors++; $display("FAIL basic_stream: got %h exp a5c33000", got); end
            checks++; if (fidx[0][0] != 1 || fidx[0][1] != 0 || nfetch[0] != 2) begin errors++;
                $display("FAIL basic_fetch_order: got %0d,%0d n=%0d exp 1,0 n=2", fidx[0][0], fidx[0][1], nfetch[0]); end
            checks++; if (load_cyc[0] != 2) begin errors++; $display("FAIL basic_load_len: got %0d exp 2", load_cyc[0]); end
            checks++; if (rstn_low[0] != 2) begin errors++; $display("FAIL basic_srst_len: got %0d exp 2", rstn_low[0]); end
            checks++; if (clk_err[0] + stab_err[0] + phase_err[0] != 0) begin errors++;
                $display("FAIL basic_timing: got clk=%0d stab=%0d phase=%0d exp 0", clk_err[0], stab_err[0], phase_err[0]); end
            checks++; if (pads[0][1] !== 16'hA5C3 || pads[0][0] !== 16'h3000) begin errors++;
                $display("FAIL basic_pads: got %h %h exp a5c3 3000", pads[0][1], pads[0][0]); end
            checks++; if (done_cnt[0] != 1 || sdata[0] !== 1'b0) begin errors++;
                $display("FAIL basic_done: got cnt=%0d data=%b exp 1 0", done_cnt[0], sdata[0]); end
        end
    endtask

    task automatic test_ignore_start();
        int n;
        int st;
        dly_a[0] = 0;
        dly_a[1] = 0;
        clear_mon(0);
        @(negedge mclk);
        start[0] = 1'b1;
        st = cyc;
        @(negedge mclk);
        start[0] = 1'b0;
        n = 0;
        while (ncap[0] < 10 && n < 200) begin @(negedge mclk); n++; end
        start[0] = 1'b1;
        @(negedge mclk);
        start[0] = 1'b0;
        n = 0;
        while (!done[0] && n < 200) begin @(negedge mclk); n++; end
        checks++; if (cyc - st != 71) begin errors++; $display("FAIL ignore_latency: got %0d exp 71", cyc - st); end
        start[0] = 1'b1;
        @(negedge mclk);
        start[0] = 1'b0;
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL ignore_done_start: got busy=%b exp 0", busy[0]); end
        repeat (10) @(negedge mclk);
        checks++; if (done_cnt[0] != 1 || rstn_low[0] != 2 || busy[0] !== 1'b0) begin errors++;
            $display("FAIL ignore_restart: got done=%0d srst=%0d busy=%b exp 1 2 0", done_cnt[0], rstn_low[0], busy[0]); end
    endtask

    task automatic test_reset_mid();
        int n;
        int lat;
        bit ok;
        logic [15:0] old1, old0;
        old1 = pads[0][1];
        old0 = pads[0][0];
        clear_mon(0);
        @(negedge mclk);
        start[0] = 1'b1;
        @(negedge mclk);
        start[0] = 1'b0;
        n = 0;
        while (ncap[0] < 7 && n < 200) begin @(negedge mclk); n++; end
        reset_n = 1'b0;
        @(negedge mclk);
        checks++; if ({busy[0], done[0], req[0], idx_a, sclk[0], sdata[0], load[0]} !== 7'd0 || rstn[0] !== 1'b1) begin errors++;
            $display("FAIL midreset_outputs: got %b rstn=%b exp 0000000 1",
                     {busy[0], done[0], req[0], idx_a, sclk[0], sdata[0], load[0]}, rstn[0]); end
        reset_n = 1'b1;
        repeat (3) @(negedge mclk);
        checks++; if (load_cyc[0] != 0 || pads[0][1] !== old1 || pads[0][0] !== old0) begin errors++;
            $display("FAIL midreset_pads: got load=%0d %h %h exp 0 %h %h", load_cyc[0], pads[0][1], pads[0][0], old1, old0); end
        words_a[1] = 16'(($urandom));
        words_a[0] = 16'(($urandom));
        run_seq(0, 500, lat, ok);
        checks++; if (!ok || lat != 71 || rstn_low[0] != 2) begin errors++;
            $display("FAIL midreset_rerun: got ok=%0d lat=%0d srst=%0d exp 1 71 2", ok, lat, rstn_low[0]); end
        @(negedge mclk);
        checks++; if (pads[0][1] !== words_a[1] || pads[0][0] !== words_a[0]) begin errors++;
            $display("FAIL midreset_reload: got %h %h exp %h %h", pads[0][1], pads[0][0], words_a[1], words_a[0]); end
    endtask

    task automatic test_six_pads();
        int lat;
        bit ok;
        int bad;
        for (int p = 0; p < 6; p++) begin words_b[p] = 16'h3000; dly_b[p] = 0; end
        run_seq(1, 2000, lat, ok);
        @(negedge mclk);
        bad = 0;
        for (int p = 0; p < 6; p++) if (pads[1][p] !== 16'h3000 || fidx[1][p] != 5 - p) bad++;
        checks++; if (!ok || lat != 595) begin errors++; $display("FAIL six_latency: got ok=%0d lat=%0d exp 1 595", ok, lat); end
        checks++; if (rstn_low[1] != 6) begin errors++; $display("FAIL six_srst_len: got %0d exp 6", rstn_low[1]); end
        checks++; if (ncap[1] != 96 || load_cyc[1] != 6) begin errors++;
            $display("FAIL six_counts: got rises=%0d load=%0d exp 96 6", ncap[1], load_cyc[1]); end
        checks++; if (phase_err[1] + clk_err[1] + stab_err[1] != 0) begin errors++;
            $display("FAIL six_timing: got phase=%0d clk=%0d stab=%0d exp 0", phase_err[1], clk_err[1], stab_err[1]); end
        checks++; if (bad != 0) begin errors++; $display("FAIL six_pads: got %0d bad pads exp 0", bad); end
    endtask

    task automatic test_spurious();
        int n;
        int st;
        int bad;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            spur[0] = 1'b1;
            junk = 16'(($urandom));
            @(negedge mclk);
            if ({busy[0], req[0], sclk[0], sdata[0], load[0]} !== 5'd0 || rstn[0] !== 1'b1) bad++;
        end
        spur[0] = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL spur_idle: got %0d disturbed cycles exp 0", bad); end
        words_a[1] = 16'(($urandom));
        words_a[0] = 16'(($urandom));
        clear_mon(0);
        @(negedge mclk);
        start[0] = 1'b1;
        st = cyc;
        @(negedge mclk);
        start[0] = 1'b0;
        n = 0;
        while (!done[0] && n < 300) begin
            spur[0] = (!req[0] && (ncap[0] % 16) >= 3 && (ncap[0] % 16) <= 12) ? 1'($urandom_range(0, 1)) : 1'b0;
            junk = 16'(($urandom));
            @(negedge mclk);
            n++;
        end
        spur[0] = 1'b0;
        checks++; if (cyc - st != 71) begin errors++; $display("FAIL spur_latency: got %0d exp 71", cyc - st); end
        @(negedge mclk);
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            logic [15:0] w;
            w = word(0, 1 - k/16);
            if (cap[0][k] !== w[15 - k%16]) bad++;
        end
        checks++; if (bad != 0 || pads[0][1] !== words_a[1] || pads[0][0] !== words_a[0]) begin errors++;
            $display("FAIL spur_data: got %0d bad bits pads %h %h exp 0 %h %h", bad, pads[0][1], pads[0][0], words_a[1], words_a[0]); end
    endtask

    task automatic test_random();
        int lat;
        bit ok;
        int bad;
        int sum;
        int d;
        for (int it = 0; it < 4; it++) begin
            d = (it == 3) ? 1 : 0;
            sum = 0;
            for (int p = 0; p < np(d); p++) begin
                if (d == 0) begin words_a[p] = 16'(($urandom)); dly_a[p] = $urandom_range(0, 3); sum += dly_a[p]; end
                else begin words_b[p] = 16'(($urandom)); dly_b[p] = $urandom_range(0, 3); sum += dly_b[p]; end
            end
            run_seq(d, 2000, lat, ok);
            @(negedge mclk);
            bad = 0;
            for (int k = 0; k < np(d)*16; k++) begin
                logic [15:0] w;
                w = word(d, np(d) - 1 - k/16);
                if (cap[d][k] !== w[15 - k%16]) bad++;
            end
            for (int p = 0; p < np(d); p++) if (pads[d][p] !== word(d, p)) bad++;
            checks++; if (!ok || lat != exp_lat(d, sum)) begin errors++;
                $display("FAIL rand_latency: got ok=%0d lat=%0d exp 1 %0d (dut %0d)", ok, lat, exp_lat(d, sum), d); end
            checks++; if (bad != 0 || ncap[d] != np(d)*16) begin errors++;
                $display("FAIL rand_data: got %0d bad rises=%0d exp 0 %0d (dut %0d)", bad, ncap[d], np(d)*16, d); end
            checks++; if (clk_err[d] + stab_err[d] + phase_err[d] != 0) begin errors++;
                $display("FAIL rand_timing: got clk=%0d stab=%0d phase=%0d exp 0", clk_err[d], stab_err[d], phase_err[d]); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < 2; p++) begin words_a[p] = '0; dly_a[p] = 0; end
        for (int p = 0; p < 6; p++) begin words_b[p] = '0; dly_b[p] = 0; end
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid();
        test_six_pads();
        test_spurious();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
